// File: rtl/neuron_pkg.sv
// Shared encodings and saturating arithmetic for the neuron potential array.
package neuron_pkg;

    typedef enum logic [1:0] {
        MODEL_LIF  = 2'b00,
        MODEL_IZH  = 2'b01,
        MODEL_QLIF = 2'b10,
        MODEL_HOLD = 2'b11
    } model_t;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'b00,
        ST_UPDATE = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    localparam int unsigned WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Operands arrive sign-extended to WIDE_W; the result is clamped to a data_w-bit signed range.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned data_w);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        sum = a + b;
        hi  = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (data_w - 1));
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/neuron_update_core.sv
// One neuron's model step (LIF / Izhikevich-lite / QLIF / hold), purely combinational.
module neuron_update_core
    import neuron_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 8
) (
    input  logic signed [DATA_W-1:0] v,
    input  logic signed [DATA_W-1:0] u,
    input  model_t                   model,
    input  logic signed [DATA_W-1:0] vth,
    input  logic signed [DATA_W-1:0] c,
    input  logic signed [DATA_W-1:0] d,
    input  logic        [4:0]        shift,
    output logic signed [DATA_W-1:0] v_next,
    output logic signed [DATA_W-1:0] u_next,
    output logic                     spike
);
    typedef logic signed [DATA_W-1:0]   data_t;
    typedef logic signed [2*DATA_W-1:0] dbl_t;

    data_t v_fire;
    data_t v_leak;
    data_t u_leak;
    data_t e;
    data_t u_kick;
    data_t q;
    dbl_t  sq;
    dbl_t  sq_scaled;

    assign v_fire    = data_t'(sat_add(wide_t'(v), -wide_t'(vth), DATA_W));
    assign v_leak    = v - (v >>> shift);
    assign u_leak    = u - (u >>> shift);
    assign e         = data_t'(sat_add(wide_t'(v), -wide_t'(u), DATA_W));
    assign u_kick    = data_t'(sat_add(wide_t'(u), wide_t'(d), DATA_W));
    // Full-width square so the quadratic term is exact before scaling back to Q format.
    assign sq        = dbl_t'(v) * dbl_t'(v);
    assign sq_scaled = sq >>> (FRAC_W + int'(shift));
    assign q         = data_t'(sat_add(wide_t'(v), wide_t'(sq_scaled), DATA_W));

    always_comb begin
        v_next = v;
        u_next = u;
        spike  = 1'b0;
        case (model)
            MODEL_LIF: begin
                if (v >= vth) begin
                    spike  = 1'b1;
                    v_next = v_fire;
                end else begin
                    v_next = v_leak;
                end
            end
            MODEL_IZH: begin
                if (e >= vth) begin
                    spike  = 1'b1;
                    v_next = c;
                    u_next = u_kick;
                end else begin
                    v_next = e;
                    u_next = u_leak;
                end
            end
            MODEL_QLIF: begin
                if (q >= vth) begin
                    spike  = 1'b1;
                    v_next = c;
                end else begin
                    v_next = q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/neuron_potential_array.sv
// Time-multiplexed membrane-potential store: accumulates weighted packets, then sweeps
// every neuron through the configured model once per timestep and publishes a spike vector.
module neuron_potential_array
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 10,
    parameter int ID_W      = 4,
    parameter int DATA_W    = 24,
    parameter int FRAC_W    = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [ID_W-1:0]   in_id,
    input  logic signed [DATA_W-1:0] in_weight,
    input  logic                     ts_end,
    input  logic                     clear_state,
    input  logic                     cfg_we,
    input  logic        [1:0]        cfg_model,
    input  logic signed [DATA_W-1:0] cfg_vth,
    input  logic signed [DATA_W-1:0] cfg_c,
    input  logic signed [DATA_W-1:0] cfg_d,
    input  logic        [4:0]        cfg_shift,
    input  logic        [ID_W-1:0]   rd_id,
    output logic        [DATA_W-1:0] rd_data,
    output logic        [N_NEURONS-1:0] spike_vec,
    output logic                     done,
    output logic                     busy,
    output logic                     err_id
);
    typedef logic signed [DATA_W-1:0] data_t;

    localparam logic [ID_W:0]   N_ID      = (ID_W + 1)'(N_NEURONS);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_NEURONS - 1);
    localparam data_t           VTH_RESET = data_t'(200 << FRAC_W);
    localparam data_t           D_RESET   = data_t'(8 << FRAC_W);

    state_t               state;
    logic [ID_W-1:0]      idx;
    data_t                v_mem [N_NEURONS];
    data_t                u_mem [N_NEURONS];
    logic [N_NEURONS-1:0] shadow;

    model_t     model_q;
    data_t      vth_q;
    data_t      c_q;
    data_t      d_q;
    logic [4:0] shift_q;

    logic            in_id_ok;
    logic            rd_id_ok;
    logic [ID_W-1:0] acc_id;
    data_t           acc_sum;
    data_t           core_v;
    data_t           core_u;
    logic            core_spike;

    assign in_ready = (state == ST_ACCUM);
    assign busy     = (state == ST_UPDATE) || (state == ST_DONE);
    assign in_id_ok = {1'b0, in_id} < N_ID;
    assign rd_id_ok = {1'b0, rd_id} < N_ID;
    assign acc_id   = in_id_ok ? in_id : '0;
    assign acc_sum  = data_t'(sat_add(wide_t'(v_mem[acc_id]), wide_t'(in_weight), DATA_W));

    neuron_update_core #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .v      (v_mem[idx]),
        .u      (u_mem[idx]),
        .model  (model_q),
        .vth    (vth_q),
        .c      (c_q),
        .d      (d_q),
        .shift  (shift_q),
        .v_next (core_v),
        .u_next (core_u),
        .spike  (core_spike)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_ACCUM;
            idx       <= '0;
            shadow    <= '0;
            spike_vec <= '0;
            done      <= 1'b0;
            err_id    <= 1'b0;
            rd_data   <= '0;
            model_q   <= MODEL_LIF;
            vth_q     <= VTH_RESET;
            c_q       <= '0;
            d_q       <= D_RESET;
            shift_q   <= 5'd3;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= '0;
                u_mem[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            rd_data <= rd_id_ok ? v_mem[rd_id] : '0;
            case (state)
                ST_ACCUM: begin
                    // Clear takes priority over a packet accepted in the same cycle.
                    if (clear_state) begin
                        err_id <= 1'b0;
                        for (int unsigned i = 0; i < N_NEURONS; i++) begin
                            v_mem[i] <= '0;
                            u_mem[i] <= '0;
                        end
                    end else if (in_valid) begin
                        if (in_id_ok) v_mem[acc_id] <= acc_sum;
                        else          err_id        <= 1'b1;
                    end
                    if (cfg_we) begin
                        model_q <= model_t'(cfg_model);
                        vth_q   <= cfg_vth;
                        c_q     <= cfg_c;
                        d_q     <= cfg_d;
                        shift_q <= cfg_shift;
                    end
                    if (ts_end) begin
                        state <= ST_UPDATE;
                        idx   <= '0;
                    end
                end
                ST_UPDATE: begin
                    v_mem[idx]  <= core_v;
                    u_mem[idx]  <= core_u;
                    shadow[idx] <= core_spike;
                    if (idx == LAST_ID) state <= ST_DONE;
                    else                idx   <= idx + 1'b1;
                end
                ST_DONE: begin
                    spike_vec <= shadow;
                    done      <= 1'b1;
                    state     <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_potential_array.sv
// Scoreboard bench: driver pushes expected spike vectors / readouts, monitor pops on done / read valid.
module tb_neuron_potential_array;
    localparam int N    = 10;
    localparam int IDW  = 4;
    localparam int DW   = 24;
    localparam int FRAC = 8;
    localparam longint VMAX = (longint'(1) << (DW - 1)) - 1;
    localparam longint VMIN = -(longint'(1) << (DW - 1));

    logic                 CLK = 1'b0;
    logic                 RST_N = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IDW-1:0]       in_id = '0;
    logic signed [DW-1:0] in_weight = '0;
    logic                 ts_end = 1'b0;
    logic                 clear_state = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [1:0]           cfg_model = '0;
    logic signed [DW-1:0] cfg_vth = '0;
    logic signed [DW-1:0] cfg_c = '0;
    logic signed [DW-1:0] cfg_d = '0;
    logic [4:0]           cfg_shift = '0;
    logic [IDW-1:0]       rd_id = '0;
    logic signed [DW-1:0] rd_data;
    logic [N-1:0]         spike_vec;
    logic                 done;
    logic                 busy;
    logic                 err_id;

    neuron_potential_array #(
        .N_NEURONS (N),
        .ID_W      (IDW),
        .DATA_W    (DW),
        .FRAC_W    (FRAC)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_id       (in_id),
        .in_weight   (in_weight),
        .ts_end      (ts_end),
        .clear_state (clear_state),
        .cfg_we      (cfg_we),
        .cfg_model   (cfg_model),
        .cfg_vth     (cfg_vth),
        .cfg_c       (cfg_c),
        .cfg_d       (cfg_d),
        .cfg_shift   (cfg_shift),
        .rd_id       (rd_id),
        .rd_data     (rd_data),
        .spike_vec   (spike_vec),
        .done        (done),
        .busy        (busy),
        .err_id      (err_id)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic rd_issue = 1'b0;
    logic rd_vld = 1'b0;

    // Reference state: plain integers, one entry per neuron.
    longint mv [N];
    longint mu [N];
    int     m_model;
    longint m_vth, m_c, m_d;
    int     m_shift;
    longint m_err;

    logic [N-1:0] spike_q [$];
    int           due_q [$];
    longint       rd_q [$];
    int           rid_q [$];

    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_issue;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    always @(negedge CLK) begin
        if (RST_N && done) begin
            done_cnt++;
            if (spike_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("spike_vec", longint'(spike_vec), longint'(spike_q.pop_front()));
                chk("done_cycle", cyc, due_q.pop_front());
            end
        end
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                chk("rd_underflow", 1, 0);
            end else begin
                int rid;
                rid = rid_q.pop_front();
                chk($sformatf("rd_data[%0d]", rid), longint'(rd_data), rd_q.pop_front());
            end
        end
    end

    function automatic longint sat(input longint x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    // Floor of x / 2^s, i.e. an arithmetic right shift expressed as division.
    function automatic longint floor_div_pow2(input longint x, input int s);
        longint p;
        p = longint'(1) << s;
        if (x >= 0) return x / p;
        return -((-x + p - 1) / p);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mu[i] = 0;
        end
        m_model = 0;
        m_vth   = 200 * 256;
        m_c     = 0;
        m_d     = 8 * 256;
        m_shift = 3;
        m_err   = 0;
    endfunction

    function automatic void apply_pkt(input int id, input longint w);
        if (id < N) mv[id] = sat(mv[id] + w);
        else        m_err  = 1;
    endfunction

    function automatic logic [N-1:0] model_sweep();
        logic [N-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            longint v, u, e, q;
            v = mv[i];
            u = mu[i];
            case (m_model)
                0: begin
                    if (v >= m_vth) begin s[i] = 1'b1; v = sat(v - m_vth); end
                    else v = v - floor_div_pow2(v, m_shift);
                end
                1: begin
                    e = sat(v - u);
                    if (e >= m_vth) begin s[i] = 1'b1; v = m_c; u = sat(u + m_d); end
                    else begin v = e; u = u - floor_div_pow2(u, m_shift); end
                end
                2: begin
                    q = sat(v + (v * v) / (longint'(1) << (FRAC + m_shift)));
                    if (q >= m_vth) begin s[i] = 1'b1; v = m_c; end
                    else v = q;
                end
                default: ;
            endcase
            mv[i] = v;
            mu[i] = u;
        end
        return s;
    endfunction

    function automatic longint rand_w();
        return longint'($urandom_range(0, 153600)) - 76800;
    endfunction

    task automatic send(input int id, input longint w);
        in_valid  = 1'b1;
        in_id     = IDW'(id);
        in_weight = DW'(w);
        @(negedge CLK);
        in_valid  = 1'b0;
        apply_pkt(id, w);
    endtask

    task automatic cfg_write(input int m, input longint vth, input longint c, input longint d, input int sh);
        cfg_we    = 1'b1;
        cfg_model = 2'(m);
        cfg_vth   = DW'(vth);
        cfg_c     = DW'(c);
        cfg_d     = DW'(d);
        cfg_shift = 5'(sh);
        @(negedge CLK);
        cfg_we  = 1'b0;
        m_model = m;
        m_vth   = vth;
        m_c     = c;
        m_d     = d;
        m_shift = sh;
    endtask

    task automatic read_check(input int id);
        rd_id    = IDW'(id);
        rd_issue = 1'b1;
        rd_q.push_back(mv[id]);
        rid_q.push_back(id);
        @(negedge CLK);
        rd_issue = 1'b0;
    endtask

    task automatic timestep(input bit with_pkt, input int id, input longint w);
        int c0;
        int d0;
        c0 = cyc;
        d0 = done_cnt;
        ts_end = 1'b1;
        if (with_pkt) begin
            in_valid  = 1'b1;
            in_id     = IDW'(id);
            in_weight = DW'(w);
        end
        @(negedge CLK);
        ts_end   = 1'b0;
        in_valid = 1'b0;
        if (with_pkt) apply_pkt(id, w);
        spike_q.push_back(model_sweep());
        due_q.push_back(c0 + 12);
        repeat (13) @(negedge CLK);
        chk("done_count", done_cnt, d0 + 1);
    endtask

    task automatic held_pkt_test();
        int c0;
        int d0;
        int waited;
        c0 = cyc;
        d0 = done_cnt;
        waited = 0;
        ts_end = 1'b1;
        @(negedge CLK);
        ts_end = 1'b0;
        spike_q.push_back(model_sweep());
        due_q.push_back(c0 + 12);
        in_valid  = 1'b1;
        in_id     = 4'd7;
        in_weight = 24'sh001234;
        cfg_we    = 1'b1;
        cfg_model = 2'b11;
        cfg_vth   = '0;
        cfg_c     = '0;
        cfg_d     = '0;
        cfg_shift = 5'd0;
        chk("in_ready_in_update", longint'(in_ready), 0);
        chk("busy_in_update", longint'(busy), 1);
        @(negedge CLK);
        cfg_we = 1'b0;
        while (!in_ready && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        chk("held_pkt_ready_again", longint'(in_ready), 1);
        @(negedge CLK);
        in_valid = 1'b0;
        apply_pkt(7, 'h1234);
        chk("held_done_count", done_cnt, d0 + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_spike_vec", longint'(spike_vec), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_err_id", longint'(err_id), 0);
        chk("reset_rd_data", longint'(rd_data), 0);

        // LIF with reset configuration
        send(3, 'h9600);
        send(3, 'h9600);
        send(0, 'h5000);
        timestep(1'b0, 0, 0);
        read_check(3);
        read_check(0);

        // Saturation at both rails
        send(5, 'h7FFFFF);
        send(5, 'h7FFFFF);
        read_check(5);
        send(6, -8388608);
        read_check(6);

        // Invalid id, then clear (with a colliding packet that must be dropped)
        send(12, 'h100);
        chk("err_id_set", longint'(err_id), m_err);
        read_check(5);
        clear_state = 1'b1;
        in_valid    = 1'b1;
        in_id       = 4'd4;
        in_weight   = 24'sh001000;
        @(negedge CLK);
        clear_state = 1'b0;
        in_valid    = 1'b0;
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mu[i] = 0;
        end
        m_err = 0;
        chk("err_id_cleared", longint'(err_id), m_err);
        read_check(5);
        read_check(4);

        // Izhikevich-lite
        cfg_write(1, 200 * 256, -64 * 256, 8 * 256, 3);
        send(2, 250 * 256);
        timestep(1'b0, 0, 0);
        read_check(2);
        timestep(1'b0, 0, 0);
        read_check(2);

        // Handshake corners
        timestep(1'b1, 4, 50 * 256);
        read_check(4);
        held_pkt_test();
        read_check(7);
        timestep(1'b0, 0, 0);
        read_check(7);
        read_check(2);

        // Randomised timesteps across all models
        for (int r = 0; r < 10; r++) begin
            int nm;
            int np;
            nm = int'($urandom_range(0, 3));
            cfg_write(nm, longint'($urandom_range(50, 400)) * 256,
                      -longint'($urandom_range(0, 100)) * 256,
                      longint'($urandom_range(0, 20)) * 256,
                      int'($urandom_range(0, 6)));
            np = int'($urandom_range(4, 10));
            for (int k = 0; k < np; k++) send(int'($urandom_range(0, N - 1)), rand_w());
            timestep(r[0], int'($urandom_range(0, N - 1)), rand_w());
            for (int k = 0; k < 3; k++) read_check(int'($urandom_range(0, N - 1)));
        end

        // Produce a spike, then reset in the middle of the next sweep
        cfg_write(0, 200 * 256, 0, 8 * 256, 3);
        send(1, 300 * 256);
        timestep(1'b0, 0, 0);
        begin
            int d0;
            d0 = done_cnt;
            ts_end = 1'b1;
            @(negedge CLK);
            ts_end = 1'b0;
            repeat (4) @(negedge CLK);
            RST_N = 1'b0;
            model_reset();
            @(negedge CLK);
            chk("midreset_spike_vec", longint'(spike_vec), 0);
            chk("midreset_busy", longint'(busy), 0);
            chk("midreset_done", longint'(done), 0);
            @(negedge CLK);
            RST_N = 1'b1;
            repeat (16) @(negedge CLK);
            chk("midreset_no_done", done_cnt, d0);
            chk("midreset_in_ready", longint'(in_ready), 1);
            read_check(1);
            read_check(3);
        end

        repeat (3) @(negedge CLK);
        chk("spike_q_drained", spike_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_potential_array.md
Name: neuron_potential_array

Overview:
- Parametrised, time-multiplexed successor to the single-neuron potential adder.
- Holds membrane potential v and recovery variable u for N_NEURONS neurons.
- Accumulates weighted input packets through a valid/ready handshake during a timestep. On ts_end it sweeps every neuron through the selected model (LIF, Izhikevich-lite or QLIF), then outputs a registered spike vector and a done pulse.
- Uses signed saturating fixed point in place of the single-neuron block's float datapath. Sits between the synapse/weight fetch logic and the spike router.

Parameters:
- N_NEURONS, 10, number of neurons held.
- ID_W, 4, neuron index width; must satisfy 2^ID_W >= N_NEURONS.
- DATA_W, 24, signed width of v, u, weights and config values.
- FRAC_W, 8, fractional bits, giving Q16.8 at the defaults.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  weight packet valid.
- in_ready  out  1  packet accepted when in_valid && in_ready.
- in_id  in  ID_W  target neuron.
- in_weight  in  DATA_W  signed weight.
- ts_end  in  1  end-of-timestep request.
- clear_state  in  1  synchronous clear of all v, u and err_id.
- cfg_we  in  1  configuration write strobe.
- cfg_model  in  2  00 LIF, 01 IZH, 10 QLIF, 11 HOLD.
- cfg_vth  in  DATA_W  threshold.
- cfg_c  in  DATA_W  post-spike reset potential (IZH, QLIF).
- cfg_d  in  DATA_W  u increment on spike (IZH).
- cfg_shift  in  5  leak/decay shift amount.
- rd_id  in  ID_W  potential readout index.
- rd_data  out  DATA_W  v[rd_id], registered, 1-cycle latency.
- spike_vec  out  N_NEURONS  spikes of the last completed timestep.
- done  out  1  one-cycle pulse when spike_vec updates.
- busy  out  1  high in UPDATE and DONE states.
- err_id  out  1  sticky flag: a packet arrived with in_id >= N_NEURONS.

Behaviour:
- Reset values:
  - all v and u = 0; spike_vec = 0; done = 0; busy = 0; err_id = 0; rd_data = 0; in_ready = 1.
  - model = 00; vth = 0x00C800 (200.0); c = 0; d = 0x000800 (8.0); shift = 3.
- Reset is asynchronous and takes effect mid-operation. An in-progress sweep is abandoned and no done pulse is produced.
- FSM states:
  - ACCUM: in_ready = 1. Each accepted packet does v[in_id] = sat(v[in_id] + in_weight). A packet with an invalid id is dropped and sets err_id.
  - ACCUM -> UPDATE on ts_end. A packet accepted in the same cycle as ts_end is applied before the sweep starts.
  - UPDATE: in_ready = 0, busy = 1. Processes neuron idx 0..N_NEURONS-1, one neuron per cycle, writing v, u and the spike bit into a shadow vector.
  - UPDATE -> DONE after idx = N_NEURONS-1.
  - DONE: spike_vec loads the shadow vector; done = 1 for exactly one cycle; the next state is ACCUM.
- Latency: with ts_end sampled at edge T, done is high in the cycle after edge T+N_NEURONS+1.
- Control inputs ignored outside ACCUM: ts_end, cfg_we and clear_state. in_valid is never accepted outside ACCUM.
- cfg_we loads all five cfg fields at once.
- If clear_state and an accepted packet occur together, clear_state wins and the packet is discarded.
- Per-neuron update, with ">=" as a signed compare:
  - LIF: if v >= vth then spike, v' = sat(v - vth); else v' = v - (v >>> shift). u is unchanged.
  - IZH: e = sat(v - u). If e >= vth then spike, v' = c, u' = sat(u + d); else v' = e, u' = u - (u >>> shift).
  - QLIF: q = sat(v + ((v*v) >>> (FRAC_W+shift))), using a 2*DATA_W product. If q >= vth then spike, v' = c; else v' = q.
  - HOLD: v, u unchanged; no spike.
- Saturation: every add/subtract clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and never wraps.
- rd_data: reads v storage as it stood at the previous edge. It is valid in every state.

Decomposition:
- Shared package neuron_pkg contains:
  - model encodings (MODEL_LIF/IZH/QLIF/HOLD);
  - FSM state encodings;
  - a sat_add function parametrised by DATA_W.
- Sub-module neuron_update_core: purely combinational, one neuron's model step. Inputs v, u, model, vth, c, d, shift; outputs v', u', spike.
- The top level owns storage, FSM, handshake and config registers.

Test Plan:
- Reset: assert RST_N=0 mid-stream -> in_ready=1, spike_vec=0, done=0, rd_data=0 one cycle after release.
- LIF:
  - Stimulus: vth=200.0. Two packets to id 3 of 0x009600 (150.0); one packet to id 0 of 0x005000 (80.0); ts_end.
  - Expected: done exactly 11 cycles later; spike_vec=0x008; v[3]=0x006400 (100.0); v[0]=0x004600 (70.0).
- Saturation: two packets of 0x7FFFFF to id 5 -> rd_data = 0x7FFFFF, not negative. One packet of 0x800000 to id 6 -> rd_data = 0x800000 exactly.
- IZH:
  - Setup: model=01, c=0xFFC000 (-64.0), d=8.0.
  - Timestep 1: packet 250.0 to id 2 -> spike, v[2]=0xFFC000, u[2]=0x000800.
  - Timestep 2: no input -> no spike, v[2]=0xFFB800 (-72.0).
- Handshake:
  - in_valid together with ts_end -> packet applied.
  - in_valid held during UPDATE -> in_ready=0 and the packet is not lost; it is accepted once ACCUM resumes.
  - cfg_we during UPDATE -> model unchanged.
- Errors and clear: packet with in_id=12 -> err_id=1 and no state change. clear_state in ACCUM -> all v=0 and err_id=0. Async reset mid-UPDATE -> no done pulse.
